// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC / instruction-fetch slice.
// Holds the pc_ctrl opcodes and the fetch FSM state encodings.
package pc_fetch_unit_pkg;

    // PC update opcodes carried on pc_ctrl.
    typedef enum logic [1:0] {
        PC_HOLD = 2'b00,
        PC_INC  = 2'b01,
        PC_JMP  = 2'b10,
        PC_REL  = 2'b11
    } pc_ctrl_e;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_DONE = 2'b10
    } fetch_state_e;

    // Width of the ROM latency down-counter (covers RD_LAT-1 for RD_LAT up to 4).
    localparam int CNT_W = 2;

endpackage : pc_fetch_unit_pkg

// File: rtl/pc_fetch_unit_if.sv
// Bus between the control unit / instruction ROM and the fetch unit.
// master = control unit + ROM side, slave = pc_fetch_unit.
interface pc_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int INS_W  = 16
) ();

    logic              en;
    logic              en_ram_in;
    logic              en_pc_pulse;
    logic [1:0]        pc_ctrl;
    logic [ADDR_W-1:0] offset_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [INS_W-1:0]  rom_data;
    logic [INS_W-1:0]  ins;
    logic              en_ram_out;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              fetch_err;

    modport master (
        output en, en_ram_in, en_pc_pulse, pc_ctrl, offset_addr, rom_data,
        input  rom_addr, rom_rd, ins, en_ram_out, pc, busy, fetch_err
    );

    modport slave (
        input  en, en_ram_in, en_pc_pulse, pc_ctrl, offset_addr, rom_data,
        output rom_addr, rom_rd, ins, en_ram_out, pc, busy, fetch_err
    );

endinterface : pc_fetch_unit_if

// File: rtl/pc_fetch_unit_pc_reg.sv
// Program counter register with its next-PC mux.
// Optional macro BRANCH_REL_EN: when defined, PC_REL adds the signed offset;
// when undefined, PC_REL holds the PC and no adder for it is built.
module pc_fetch_unit_pc_reg
    import pc_fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              pulse_i,
    input  logic [1:0]        ctrl_i,
    input  logic [ADDR_W-1:0] offset_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // Next-PC selection; only an enabled update strobe changes the PC.
    always_comb begin
        pc_d = pc_q;
        if (en_i && pulse_i) begin
            case (pc_ctrl_e'(ctrl_i))
                PC_INC:  pc_d = pc_q + ADDR_W'(1);
                PC_JMP:  pc_d = offset_i;
`ifdef BRANCH_REL_EN
                // Adding an ADDR_W-bit two's-complement offset modulo 2^ADDR_W
                // is the same as adding its sign extension and truncating.
                PC_REL:  pc_d = pc_q + offset_i;
`endif
                default: pc_d = pc_q;
            endcase
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule : pc_fetch_unit_pc_reg

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch sequencer feeding the control unit.
// A fetch request latches the current PC onto rom_addr, waits RD_LAT cycles
// for the ROM and returns the word on ins with a one-cycle en_ram_out strobe.
// Optional macro BRANCH_REL_EN enables the signed relative PC branch.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int INS_W    = 16,
    parameter int RD_LAT   = 1,
    parameter int RESET_PC = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_unit_if.slave bus
);

    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rom_rd_q, rom_rd_d;
    logic [INS_W-1:0]  ins_q, ins_d;
    logic              en_ram_out_q, en_ram_out_d;
    logic              busy_q, busy_d;
    logic              fetch_err_q, fetch_err_d;
    logic [ADDR_W-1:0] pc_w;

    pc_fetch_unit_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (bus.en),
        .pulse_i  (bus.en_pc_pulse),
        .ctrl_i   (bus.pc_ctrl),
        .offset_i (bus.offset_addr),
        .pc_o     (pc_w)
    );

    // Fetch FSM next state and outputs; with en low everything holds so a
    // pending strobe survives the stall.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rom_addr_d   = rom_addr_q;
        rom_rd_d     = rom_rd_q;
        ins_d        = ins_q;
        en_ram_out_d = en_ram_out_q;
        busy_d       = busy_q;
        fetch_err_d  = fetch_err_q;
        if (bus.en) begin
            rom_rd_d = 1'b0;
            case (state_q)
                // DONE retires the strobe and accepts a new request just like IDLE,
                // which makes back-to-back fetches possible.
                S_IDLE, S_DONE: begin
                    en_ram_out_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                    if (bus.en_ram_in) begin
                        // Uses the PC before any same-cycle update.
                        rom_addr_d = pc_w;
                        rom_rd_d   = 1'b1;
                        busy_d     = 1'b1;
                        cnt_d      = CNT_W'(RD_LAT - 1);
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.en_ram_in) begin
                        fetch_err_d = 1'b1;
                    end
                    if (cnt_q == '0) begin
                        ins_d        = bus.rom_data;
                        en_ram_out_d = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Fetch FSM and output registers; reset discards any in-flight fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rom_addr_q   <= '0;
            rom_rd_q     <= 1'b0;
            ins_q        <= '0;
            en_ram_out_q <= 1'b0;
            busy_q       <= 1'b0;
            fetch_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rom_addr_q   <= rom_addr_d;
            rom_rd_q     <= rom_rd_d;
            ins_q        <= ins_d;
            en_ram_out_q <= en_ram_out_d;
            busy_q       <= busy_d;
            fetch_err_q  <= fetch_err_d;
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.rom_rd     = rom_rd_q;
    assign bus.ins        = ins_q;
    assign bus.en_ram_out = en_ram_out_q;
    assign bus.busy       = busy_q;
    assign bus.fetch_err  = fetch_err_q;
    assign bus.pc         = pc_w;

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (RD_LAT=1 and RD_LAT=3) share one
// stimulus stream and are compared every cycle against a transaction-level
// model. Honours BRANCH_REL_EN for the PC_REL expectation.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        req;
    logic        pulse;
    logic [1:0]  ctrl;
    logic [7:0]  offs;
    logic [15:0] rom [256];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_fetch_unit_if #(.ADDR_W(8), .INS_W(16)) if1 ();
    pc_fetch_unit_if #(.ADDR_W(8), .INS_W(16)) if3 ();

    assign if1.en = en;  assign if1.en_ram_in = req;  assign if1.en_pc_pulse = pulse;
    assign if1.pc_ctrl = ctrl;  assign if1.offset_addr = offs;
    assign if1.rom_data = rom[if1.rom_addr];
    assign if3.en = en;  assign if3.en_ram_in = req;  assign if3.en_pc_pulse = pulse;
    assign if3.pc_ctrl = ctrl;  assign if3.offset_addr = offs;
    assign if3.rom_data = rom[if3.rom_addr];

    pc_fetch_unit #(.ADDR_W(8), .INS_W(16), .RD_LAT(1), .RESET_PC(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    pc_fetch_unit #(.ADDR_W(8), .INS_W(16), .RD_LAT(3), .RESET_PC(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3.slave));

    // Transaction model: m_n counts enabled clock edges since reset; each
    // accepted fetch k records its acceptance edge and its completion edge.
    int          lat [2] = '{1, 3};
    int          m_n;
    logic [7:0]  m_pc;
    bit          m_valid [2];
    int          m_acc [2];
    int          m_done [2];
    logic [7:0]  m_addr [2];
    logic [15:0] m_ins [2];
    bit          m_err [2];

    task automatic model_reset();
        m_n  = 0;
        m_pc = 8'h00;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_acc[k] = 0; m_done[k] = 0;
            m_addr[k] = 8'h00; m_ins[k] = 16'h0000; m_err[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int d;
        m_n++;
        for (int k = 0; k < 2; k++) begin
            bit accept;
            accept = 1'b0;
            if (req) begin
                if (!m_valid[k] || m_n > m_done[k]) accept = 1'b1;
                else m_err[k] = 1'b1;
            end
            if (m_valid[k] && m_n == m_done[k]) m_ins[k] = rom[m_addr[k]];
            if (accept) begin
                m_addr[k]  = m_pc;
                m_acc[k]   = m_n;
                m_done[k]  = m_n + lat[k];
                m_valid[k] = 1'b1;
            end
        end
        if (pulse) begin
            case (ctrl)
                2'd1: m_pc = 8'((int'(m_pc) + 1) % 256);
                2'd2: m_pc = offs;
                2'd3: begin
`ifdef BRANCH_REL_EN
                    d = int'(offs);
                    if (d >= 128) d -= 256;
                    m_pc = 8'((int'(m_pc) + d + 256) % 256);
`else
                    d = 0;
`endif
                end
                default: ;
            endcase
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int k, input logic [7:0] pc_o, input logic [7:0] addr_o,
                             input logic rd_o, input logic [15:0] ins_o, input logic out_o,
                             input logic busy_o, input logic err_o);
        string p;
        p = $sformatf("lat%0d_", lat[k]);
        check({p, "pc"},       {24'd0, pc_o},   {24'd0, m_pc});
        check({p, "rom_addr"}, {24'd0, addr_o}, {24'd0, m_addr[k]});
        check({p, "rom_rd"},   {31'd0, rd_o},   {31'd0, m_valid[k] && m_acc[k] == m_n});
        check({p, "ins"},      {16'd0, ins_o},  {16'd0, m_ins[k]});
        check({p, "en_ram_out"}, {31'd0, out_o}, {31'd0, m_valid[k] && m_done[k] == m_n});
        check({p, "busy"},     {31'd0, busy_o}, {31'd0, m_valid[k] && m_n <= m_done[k]});
        check({p, "fetch_err"}, {31'd0, err_o}, {31'd0, m_err[k]});
    endtask

    task automatic check_all();
        check_dut(0, if1.pc, if1.rom_addr, if1.rom_rd, if1.ins, if1.en_ram_out, if1.busy, if1.fetch_err);
        check_dut(1, if3.pc, if3.rom_addr, if3.rom_rd, if3.ins, if3.en_ram_out, if3.busy, if3.fetch_err);
    endtask

    // One clock: model follows enabled edges, outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (rst_n && en) model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
    endtask

    initial begin
        int first;
        int cnt;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0] = 16'hA5C3;
        en = 1'b1; req = 1'b0; pulse = 1'b0; ctrl = 2'd0; offs = 8'h00;

        // Reset state, held across two edges.
        do_reset();
        tick(); tick();
        check("reset_pc", {24'd0, if1.pc}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Fetch at pc=0, RD_LAT=1.
        req = 1'b1;
        tick();
        req = 1'b0;
        check("t1_rom_rd", {31'd0, if1.rom_rd}, 32'd1);
        tick();
        check("t1_strobe", {31'd0, if1.en_ram_out}, 32'd1);
        check("t1_ins", {16'd0, if1.ins}, 32'h0000A5C3);
        tick();
        check("t1_single", {31'd0, if1.en_ram_out}, 32'd0);
        repeat (4) tick();

        // PC wrap and jump.
        pulse = 1'b1; ctrl = 2'd2; offs = 8'hFF; tick();
        ctrl = 2'd1; tick();
        check("wrap_pc", {24'd0, if1.pc}, 32'h00);
        ctrl = 2'd2; offs = 8'h40; tick();
        check("jump_pc", {24'd0, if1.pc}, 32'h40);

        // Relative branch (or hold when disabled).
        offs = 8'h10; tick();
        ctrl = 2'd3; offs = 8'hFC; tick();
`ifdef BRANCH_REL_EN
        check("rel_pc", {24'd0, if1.pc}, 32'h0C);
`else
        check("rel_pc", {24'd0, if1.pc}, 32'h10);
`endif
        pulse = 1'b0; ctrl = 2'd0;

        // RD_LAT=3: second request one cycle after the first.
        first = 0; cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            req = (i <= 2);
            tick();
            if (if3.en_ram_out) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        check("busy_err", {31'd0, if3.fetch_err}, 32'd1);
        check("busy_first", first, 4);
        check("busy_count", cnt, 1);

        // Request with simultaneous PC increment at pc=5, then a 3-cycle stall.
        pulse = 1'b1; ctrl = 2'd2; offs = 8'h05; tick();
        first = 0; cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            req   = (i == 1);
            pulse = (i == 1);
            ctrl  = 2'd1;
            en    = !(i >= 3 && i <= 5);
            tick();
            if (i == 1) begin
                check("same_addr", {24'd0, if3.rom_addr}, 32'h05);
                check("same_pc", {24'd0, if3.pc}, 32'h06);
            end
            if (if3.en_ram_out && en) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        check("stall_first", first, 7);
        check("stall_count", cnt, 1);
        en = 1'b1; pulse = 1'b0; ctrl = 2'd0;

        // Reset in the middle of a RD_LAT=3 fetch.
        req = 1'b1; tick();
        req = 1'b0; tick();
        do_reset();
        check("rst_busy", {31'd0, if3.busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (if3.en_ram_out || if1.en_ram_out) cnt++;
        end
        check("rst_no_strobe", cnt, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            req   = ($urandom_range(0, 2) == 0);
            pulse = ($urandom_range(0, 2) == 0);
            ctrl  = 2'($urandom);
            offs  = 8'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_pc_fetch_unit
